// File: rtl/integration_pkg.sv
// Shared AHB encodings and burst-length lookup used by the arbiter and the master/slave agents.
package integration_pkg;

  typedef enum logic [1:0] {
    TransIdle   = 2'b00,
    TransBusy   = 2'b01,
    TransNonseq = 2'b10,
    TransSeq    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    BurstSingle = 3'd0,
    BurstIncr   = 3'd1,
    BurstWrap4  = 3'd2,
    BurstIncr4  = 3'd3,
    BurstWrap8  = 3'd4,
    BurstIncr8  = 3'd5,
    BurstWrap16 = 3'd6,
    BurstIncr16 = 3'd7
  } hburst_e;

  typedef enum logic [1:0] {
    RespOkay  = 2'b00,
    RespError = 2'b01,
    RespRetry = 2'b10,
    RespSplit = 2'b11
  } hresp_e;

  localparam int unsigned IdxW = 4;
  localparam int unsigned RemW = 5;

  // Beats still to come after the NONSEQ; undefined-length INCR counts as a single beat.
  function automatic logic [RemW-1:0] burst_beats_left(hburst_e burst);
    case (burst)
      BurstIncr4, BurstWrap4:   return 5'd3;
      BurstIncr8, BurstWrap8:   return 5'd7;
      BurstIncr16, BurstWrap16: return 5'd15;
      default:                  return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection: fixed lowest-index priority, or round-robin starting after
// the pointer when ARB_ROUND_ROBIN_EN is defined. With no requester the default master wins.
module arb_pick
  import integration_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 4,
  parameter int unsigned DEFAULT_MASTER = 0
) (
  input  logic [NUM_MASTERS-1:0] req,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic [IdxW-1:0]        ptr,
  output logic                   found,
`endif
  output logic [IdxW-1:0]        winner
);

`ifdef ARB_ROUND_ROBIN_EN
  // Two passes: indices above the pointer first, then wrap around to the pointer itself.
  always_comb begin
    found  = 1'b0;
    winner = IdxW'(DEFAULT_MASTER);
    for (int unsigned c = 0; c < NUM_MASTERS; c++) begin
      if (!found && req[c] && (IdxW'(c) > ptr)) begin
        found  = 1'b1;
        winner = IdxW'(c);
      end
    end
    for (int unsigned c = 0; c < NUM_MASTERS; c++) begin
      if (!found && req[c] && (IdxW'(c) <= ptr)) begin
        found  = 1'b1;
        winner = IdxW'(c);
      end
    end
  end
`else
  logic hit;

  always_comb begin
    hit    = 1'b0;
    winner = IdxW'(DEFAULT_MASTER);
    for (int unsigned c = 0; c < NUM_MASTERS; c++) begin
      if (!hit && req[c]) begin
        hit    = 1'b1;
        winner = IdxW'(c);
      end
    end
  end
`endif

endmodule

// File: rtl/ahb_arbiter.sv
// AHB bus arbiter: burst/lock-aware grant handover with one-hot hgrant, hmaster and hmastlock.
// Define ARB_ROUND_ROBIN_EN for round-robin selection; fixed priority otherwise.
module ahb_arbiter
  import integration_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 4,
  parameter int unsigned DEFAULT_MASTER = 0
) (
  input  logic                   hclk,
  input  logic                   hreset,
  input  logic [NUM_MASTERS-1:0] hbusreq,
  input  logic [NUM_MASTERS-1:0] hlock,
  input  logic [1:0]             htrans,
  input  logic [2:0]             hburst,
  input  logic                   hready,
  input  logic [1:0]             hresp,
  output logic [NUM_MASTERS-1:0] hgrant,
  output logic [3:0]             hmaster,
  output logic                   hmastlock
);

  localparam logic [NUM_MASTERS-1:0] GrantOne = (NUM_MASTERS)'(1);
  localparam logic [IdxW-1:0]        DefIdx   = IdxW'(DEFAULT_MASTER);

  logic [NUM_MASTERS-1:0] hgrant_q;
  logic [IdxW-1:0]        grant_idx_q;
  logic [IdxW-1:0]        hmaster_q;
  logic                   hmastlock_q;
  logic [RemW-1:0]        rem_q, rem_d;
  logic [IdxW-1:0]        win_idx;
  logic                   lock_hold;
  logic                   arb_ok;

`ifdef ARB_ROUND_ROBIN_EN
  logic [IdxW-1:0] ptr_q;
  logic            win_found;
`endif

  arb_pick #(
    .NUM_MASTERS    (NUM_MASTERS),
    .DEFAULT_MASTER (DEFAULT_MASTER)
  ) u_pick (
    .req    (hbusreq),
`ifdef ARB_ROUND_ROBIN_EN
    .ptr    (ptr_q),
    .found  (win_found),
`endif
    .winner (win_idx)
  );

  // An error-class response clears the count on its first cycle so the second cycle can hand over.
  always_comb begin
    rem_d = rem_q;
    if (!hready && (hresp_e'(hresp) != RespOkay)) begin
      rem_d = '0;
    end else if (hready) begin
      case (htrans_e'(htrans))
        TransNonseq: rem_d = burst_beats_left(hburst_e'(hburst));
        TransSeq:    rem_d = (rem_q == '0) ? '0 : rem_q - 5'd1;
        default:     rem_d = rem_q;
      endcase
    end
  end

  // hgrant is one-hot, so the mask picks out the owner's lock request.
  assign lock_hold = |(hlock & hgrant_q);
  assign arb_ok    = hready && !lock_hold &&
                     ((htrans_e'(htrans) == TransIdle) || (rem_d == '0));

  always_ff @(posedge hclk) begin
    if (hreset) begin
      hgrant_q    <= GrantOne << DefIdx;
      grant_idx_q <= DefIdx;
      hmaster_q   <= DefIdx;
      hmastlock_q <= 1'b0;
      rem_q       <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      ptr_q       <= DefIdx;
`endif
    end else begin
      rem_q <= rem_d;
      if (arb_ok) begin
        hgrant_q    <= GrantOne << win_idx;
        grant_idx_q <= win_idx;
`ifdef ARB_ROUND_ROBIN_EN
        if (win_found && (win_idx != grant_idx_q)) ptr_q <= win_idx;
`endif
      end
      if (hready) begin
        hmaster_q   <= grant_idx_q;
        hmastlock_q <= lock_hold;
      end
    end
  end

  assign hgrant    = hgrant_q;
  assign hmaster   = hmaster_q;
  assign hmastlock = hmastlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Self-checking bench for ahb_arbiter: vector table through a scoreboard queue, plus a policy run.
module tb_ahb_arbiter;

  localparam logic [1:0] TI = 2'b00, TB = 2'b01, TN = 2'b10, TS = 2'b11;
  localparam logic [2:0] BSingle = 3'd0, BWrap4 = 3'd2, BIncr4 = 3'd3, BWrap8 = 3'd4;
  localparam logic [2:0] BIncr8 = 3'd5, BIncr16 = 3'd7;
  localparam logic [1:0] ROk = 2'b00, RRetry = 2'b10;

  logic       hclk = 1'b0;
  logic       hreset;
  logic [3:0] hbusreq, hlock;
  logic [1:0] htrans;
  logic [2:0] hburst;
  logic       hready;
  logic [1:0] hresp;
  logic [3:0] hgrant;
  logic [3:0] hmaster;
  logic       hmastlock;

  ahb_arbiter #(
    .NUM_MASTERS    (4),
    .DEFAULT_MASTER (0)
  ) dut (
    .hclk      (hclk),
    .hreset    (hreset),
    .hbusreq   (hbusreq),
    .hlock     (hlock),
    .htrans    (htrans),
    .hburst    (hburst),
    .hready    (hready),
    .hresp     (hresp),
    .hgrant    (hgrant),
    .hmaster   (hmaster),
    .hmastlock (hmastlock)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    string      name;
    logic       rst;
    logic [3:0] req;
    logic [3:0] lock;
    logic [1:0] trans;
    logic [2:0] burst;
    logic       ready;
    logic [1:0] resp;
    logic [3:0] g;
    logic [3:0] m;
    logic       ml;
    logic [4:0] rem;   // 5'h1f: not checked
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic add(input string name, input logic rst, input logic [3:0] req,
                     input logic [3:0] lock, input logic [1:0] trans, input logic [2:0] burst,
                     input logic ready, input logic [1:0] resp, input logic [3:0] g,
                     input logic [3:0] m, input logic ml, input logic [4:0] rem);
    vec_t v;
    v.name = name; v.rst = rst; v.req = req; v.lock = lock; v.trans = trans; v.burst = burst;
    v.ready = ready; v.resp = resp; v.g = g; v.m = m; v.ml = ml; v.rem = rem;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    hreset  = v.rst;
    hbusreq = v.req;
    hlock   = v.lock;
    htrans  = v.trans;
    hburst  = v.burst;
    hready  = v.ready;
    hresp   = v.resp;
  endtask

  task automatic run_and_check(input vec_t v);
    vec_t e;
    drive(v);
    exp_q.push_back(v);
    @(posedge hclk);
    #1;
    e = exp_q.pop_front();
    check({e.name, ".hgrant"}, 32'(hgrant), 32'(e.g));
    check({e.name, ".hmaster"}, 32'(hmaster), 32'(e.m));
    check({e.name, ".hmastlock"}, 32'(hmastlock), 32'(e.ml));
    if (e.rem != 5'h1f) check({e.name, ".rem"}, 32'(dut.rem_q), 32'(e.rem));
  endtask

  function automatic logic [3:0] idx_of(input logic [3:0] oh);
    logic [3:0] r = 4'd0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = 4'(i);
    return r;
  endfunction

  initial begin
    logic [3:0] pol_g[5];
    logic [3:0] prev_g;
    vec_t       v;

    // name             rst req    lock   tr  burst    rdy   resp    g      m  ml rem
    add("reset_a",        1, 4'h0, 4'h0, TI, BSingle, 1'b1, ROk,    4'h1, 0, 0, 0);
    add("reset_b",        1, 4'h6, 4'h0, TI, BSingle, 1'b1, ROk,    4'h1, 0, 0, 0);
    add("grant_m1",       0, 4'h2, 4'h0, TI, BSingle, 1'b1, ROk,    4'h2, 0, 0, 0);
    add("incr4_nonseq",   0, 4'h2, 4'h0, TN, BIncr4,  1'b1, ROk,    4'h2, 1, 0, 3);
    add("incr4_b2",       0, 4'h6, 4'h0, TS, BIncr4,  1'b1, ROk,    4'h2, 1, 0, 2);
    add("incr4_b3",       0, 4'h6, 4'h0, TS, BIncr4,  1'b1, ROk,    4'h2, 1, 0, 1);
    add("incr4_b4",       0, 4'h4, 4'h0, TS, BIncr4,  1'b1, ROk,    4'h4, 1, 0, 0);
    add("m2_single",      0, 4'h4, 4'h0, TN, BSingle, 1'b1, ROk,    4'h4, 2, 0, 0);
    add("lock_grant",     0, 4'h8, 4'h8, TI, BSingle, 1'b1, ROk,    4'h8, 2, 0, 0);
    add("lock_t1",        0, 4'hf, 4'h8, TN, BSingle, 1'b1, ROk,    4'h8, 3, 1, 0);
    add("lock_t2",        0, 4'hf, 4'h8, TN, BSingle, 1'b1, ROk,    4'h8, 3, 1, 0);
    add("lock_t3",        0, 4'hf, 4'h8, TN, BSingle, 1'b1, ROk,    4'h8, 3, 1, 0);
    add("lock_drop",      0, 4'hf, 4'h0, TI, BSingle, 1'b1, ROk,    4'h1, 3, 0, 0);
    add("incr8_nonseq",   0, 4'h3, 4'h0, TN, BIncr8,  1'b1, ROk,    4'h1, 0, 0, 7);
    add("incr8_b2",       0, 4'h3, 4'h0, TS, BIncr8,  1'b1, ROk,    4'h1, 0, 0, 6);
    add("incr8_b3",       0, 4'h3, 4'h0, TS, BIncr8,  1'b1, ROk,    4'h1, 0, 0, 5);
    add("incr8_b4",       0, 4'h3, 4'h0, TS, BIncr8,  1'b1, ROk,    4'h1, 0, 0, 4);
    add("incr8_b5",       0, 4'h3, 4'h0, TS, BIncr8,  1'b1, ROk,    4'h1, 0, 0, 3);
    add("incr8_wait1",    0, 4'h3, 4'h0, TS, BIncr8,  1'b0, ROk,    4'h1, 0, 0, 3);
    add("incr8_wait2",    0, 4'h3, 4'h0, TS, BIncr8,  1'b0, ROk,    4'h1, 0, 0, 3);
    add("incr8_wait3",    0, 4'h3, 4'h0, TS, BIncr8,  1'b0, ROk,    4'h1, 0, 0, 3);
    add("incr8_b6",       0, 4'h3, 4'h0, TS, BIncr8,  1'b1, ROk,    4'h1, 0, 0, 2);
    add("incr8_b7",       0, 4'h3, 4'h0, TS, BIncr8,  1'b1, ROk,    4'h1, 0, 0, 1);
    add("incr8_b8",       0, 4'h2, 4'h0, TS, BIncr8,  1'b1, ROk,    4'h2, 0, 0, 0);
    add("wrap8_nonseq",   0, 4'h2, 4'h0, TN, BWrap8,  1'b1, ROk,    4'h2, 1, 0, 7);
    add("wrap8_b2",       0, 4'h6, 4'h0, TS, BWrap8,  1'b1, ROk,    4'h2, 1, 0, 6);
    add("retry_cycle1",   0, 4'h6, 4'h0, TS, BWrap8,  1'b0, RRetry, 4'h2, 1, 0, 0);
    add("retry_cycle2",   0, 4'h4, 4'h0, TI, BWrap8,  1'b1, RRetry, 4'h4, 1, 0, 0);
    add("m2_after_retry", 0, 4'h4, 4'h0, TN, BSingle, 1'b1, ROk,    4'h4, 2, 0, 0);
    add("no_req_default", 0, 4'h0, 4'h0, TI, BSingle, 1'b1, ROk,    4'h1, 2, 0, 0);
    add("no_req_hold",    0, 4'h0, 4'h0, TI, BSingle, 1'b1, ROk,    4'h1, 0, 0, 0);
    add("grant_m1_again", 0, 4'h2, 4'h0, TI, BSingle, 1'b1, ROk,    4'h2, 0, 0, 0);
    add("incr16_locked",  0, 4'h2, 4'h2, TN, BIncr16, 1'b1, ROk,    4'h2, 1, 1, 15);
    add("reset_mid",      1, 4'h2, 4'h2, TS, BIncr16, 1'b1, ROk,    4'h1, 0, 0, 0);
    add("post_reset_arb", 0, 4'h2, 4'h2, TS, BIncr16, 1'b1, ROk,    4'h2, 0, 0, 0);
    add("incr4_m1",       0, 4'h2, 4'h0, TN, BIncr4,  1'b1, ROk,    4'h2, 1, 0, 3);
    add("busy_holds",     0, 4'h6, 4'h0, TB, BIncr4,  1'b1, ROk,    4'h2, 1, 0, 3);

    foreach (vecs[i]) run_and_check(vecs[i]);

    // Policy run: all four masters request continuously with SINGLE transfers.
`ifdef ARB_ROUND_ROBIN_EN
    pol_g = '{4'h2, 4'h4, 4'h8, 4'h1, 4'h2};
`else
    pol_g = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h1};
`endif
    v = vecs[0];
    v.name = "policy_reset";
    run_and_check(v);
    prev_g = 4'h1;
    for (int k = 0; k < 5; k++) begin
      v.name  = $sformatf("policy_%0d", k);
      v.rst   = 1'b0;
      v.req   = 4'hf;
      v.lock  = 4'h0;
      v.trans = (k == 0) ? TI : TN;
      v.burst = BSingle;
      v.ready = 1'b1;
      v.resp  = ROk;
      v.g     = pol_g[k];
      v.m     = idx_of(prev_g);
      v.ml    = 1'b0;
      v.rem   = 5'h1f;
      run_and_check(v);
      prev_g = pol_g[k];
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ahb_arbiter.md
AHB_ARBITER -- requirements
Module: ahb_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 4, meaning number of bus masters (legal range 1..16).
REQ-002 SHALL have parameter DEFAULT_MASTER, default 0, meaning the master granted when no master requests.
REQ-003 SHALL have ports `hclk  input  1  bus clock`; one clock only, all state on its rising edge.
REQ-004 SHALL have ports `hreset  input  1  synchronous, active-high reset`.
REQ-005 SHALL have ports `hbusreq  input  NUM_MASTERS  per-master bus request`.
REQ-006 SHALL have ports `hlock  input  NUM_MASTERS  per-master locked-access request`.
REQ-007 SHALL have ports `htrans  input  2  transfer type of the current bus owner`, and `hburst  input  3  burst type of the current bus owner`.
REQ-008 SHALL have ports `hready  input  1  transfer-done from the selected slave`, and `hresp  input  2  slave response`.
REQ-009 SHALL have ports `hgrant  output  NUM_MASTERS  one-hot grant`.
REQ-010 SHALL have ports `hmaster  output  4  index of the current address-phase owner`, and `hmastlock  output  1  current transfer is locked`.

Function
REQ-011 SHALL keep hgrant one-hot at all times, including with zero requests, when it equals DEFAULT_MASTER.
REQ-012 SHALL track remaining beats rem (5 bits) of the owner's burst:
  - NONSEQ accepted (hready=1) loads burst length - 1: SINGLE/INCR=0, INCR4/WRAP4=3, INCR8/WRAP8=7, INCR16/WRAP16=15.
  - SEQ accepted decrements rem, saturating at 0.
  - BUSY and IDLE leave rem unchanged.
REQ-013 SHALL treat undefined-length INCR as re-arbitrable on every accepted beat.
REQ-014 SHALL define arb_ok as follows:
  - arb_ok = hready=1 AND lock_hold=0 AND (htrans=IDLE OR next value of rem = 0).
  - If arb_ok, hgrant is updated at the next edge from the winner among hbusreq.
  - Otherwise hgrant holds.
REQ-015 SHALL give the new master hgrant during the last beat's data phase, so it drives its first address on the cycle after hready=1 (standard AHB handover, zero dead cycles).
REQ-016 SHALL update hmaster to the granted index only on an edge where hready=1, giving 1-cycle latency from hgrant change to hmaster change when hready=1.
REQ-017 SHALL set lock_hold = hlock of the currently granted master; while lock_hold=1, hgrant SHALL not change regardless of other requests.
REQ-018 SHALL register hmastlock from hlock of the granted master on edges with hready=1, aligned with hmaster.
REQ-019 SHALL, on hresp = ERROR/RETRY/SPLIT (2'b01/2'b10/2'b11) with hready=0 (first response cycle), clear rem to 0 so arbitration reopens at the second response cycle.
REQ-020 SHALL, if the granted master drops hbusreq with no burst pending (rem=0), re-arbitrate on the next arb_ok edge; if no requester exists, grant DEFAULT_MASTER.
REQ-021 SHALL use fixed-priority selection when the feature of REQ-025 is disabled: lowest index wins.
REQ-022 SHALL, on simultaneous requests while arb_ok, compute the winner in the same cycle; ties are resolved by the selection policy only.

Reset
REQ-023 SHALL, while hreset=1 at a rising edge, set:
  - hgrant = one-hot(DEFAULT_MASTER), hmaster = DEFAULT_MASTER, hmastlock = 0.
  - rem = 0, round-robin pointer = DEFAULT_MASTER.
REQ-024 SHALL abandon a reset asserted mid-burst or mid-lock immediately (no completion); the first post-reset arbitration occurs at the first edge with hreset=0 and arb_ok.

Configuration
REQ-025 SHALL, when macro ARB_ROUND_ROBIN_EN is defined, use round-robin selection:
  - Search starts at (last winner + 1) mod NUM_MASTERS.
  - The pointer updates only when a grant actually changes to a requesting master.
  - When undefined, fixed priority per REQ-021 applies and no pointer register exists.

Structure
REQ-026 SHALL take htrans/hburst/hresp encodings as typedef enums, plus a burst-length lookup function, from integration_pkg (shared with the master/slave agents).
REQ-027 SHALL place the combinational winner selection (priority or round-robin mask) in sub-module arb_pick; counters, lock handling and output registers remain in ahb_arbiter.

Verification
REQ-028 SHALL cover the following directed scenarios:
  - Reset: hreset=1 for 2 cycles, NUM_MASTERS=4 -> hgrant=4'b0001, hmaster=0, hmastlock=0.
  - Burst hold: M1 granted issues INCR4 (NONSEQ+3 SEQ, hready=1), M2 requests at beat 2 -> hgrant stays 4'b0010 until the edge after the 4th address, then 4'b0100; hmaster=2 one cycle later.
  - Lock: M3 hlock=1 with 3 SINGLE transfers while M0..M2 request -> hgrant=4'b1000 and hmastlock=1 throughout; grant moves the first arb_ok edge after hlock drops.
  - Wait states: M0 INCR8 with hready=0 for 3 cycles on beat 5 -> rem holds at 3 during waits; no grant change.
  - Early termination: RETRY response on beat 2 of WRAP8 with M2 requesting -> rem=0 after first response cycle; hgrant=4'b0100 by the second response cycle.
  - Policy with ARB_ROUND_ROBIN_EN: all four request continuously with SINGLE transfers -> grant order 1,2,3,0,1; without the macro, M0 retains grant indefinitely.
